// File: rtl/config_reg_pkg.sv
// Shared address map and field layout for the trigger configuration register file.
// Every decoder and field slice in config_reg refers to these names.
package config_reg_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 21;
    localparam int GRP_COUNT = 5;

    localparam logic [ADDR_W-1:0] ADDR_CTRL              = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_CMD               = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP0        = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP1        = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP2        = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP3        = 8'h05;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP4        = 8'h06;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_BURST_SEL   = 8'h07;
    localparam logic [ADDR_W-1:0] ADDR_HIT_AB_SEL        = 8'h08;
    localparam logic [ADDR_W-1:0] ADDR_HIT_MASK          = 8'h09;
    localparam logic [ADDR_W-1:0] ADDR_MONIT_FIX_SEL     = 8'h0A;
    localparam logic [ADDR_W-1:0] ADDR_BUSY_CFG          = 8'h0B;
    localparam logic [ADDR_W-1:0] ADDR_ACD_CSI_TIM_DIFF  = 8'h0C;
    localparam logic [ADDR_W-1:0] ADDR_ACD_CSI_ALIGN     = 8'h0D;
    localparam logic [ADDR_W-1:0] ADDR_CAL_ALIGN         = 8'h0E;
    localparam logic [ADDR_W-1:0] ADDR_TRG_MATCH_WIN     = 8'h0F;
    localparam logic [ADDR_W-1:0] ADDR_TRG_DEAD_TIME     = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_LOGIC_GRP_OE      = 8'h11;
    localparam logic [ADDR_W-1:0] ADDR_CYCLED_TRG_PERIOD = 8'h12;
    localparam logic [ADDR_W-1:0] ADDR_CYCLED_TRG_NUM    = 8'h13;
    localparam logic [ADDR_W-1:0] ADDR_EXT_TRG_DELAY     = 8'h14;

    // Field positions inside the 16-bit data word
    localparam int CTRL_TRG_ENB_BIT      = 0;
    localparam int CTRL_DATA_TRANS_BIT   = 1;
    localparam int CMD_RST_BIT           = 0;
    localparam int CMD_CYCLED_BGN_BIT    = 1;
    localparam int GRP_MUX_LSB           = 0;
    localparam int GRP_MUX_W             = 8;
    localparam int GRP_SEL_LSB           = 8;
    localparam int GRP_SEL_W             = 2;
    localparam int COINCID_DIV_LSB       = 10;
    localparam int COINCID_DIV_W         = 6;
    localparam int HIT_MONIT_LSB         = 0;
    localparam int HIT_MONIT_W           = 3;
    localparam int BUSY_MONIT_BIT        = 3;
    localparam int BUSY_AB_LSB           = 0;
    localparam int BUSY_MASK_LSB         = 2;
    localparam int BUSY_IGNORE_BIT       = 4;
    localparam int ALIGN_W               = 4;
    localparam int BYTE_W                = 8;

    function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(REG_COUNT);
    endfunction

endpackage

// File: rtl/config_reg.sv
// Write-only configuration register file for the trigger board: one decoded
// register per address, command pulses, and a count of accepted writes.
module config_reg
    import config_reg_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_in,
    input  logic [7:0]  wr_addr_in,
    input  logic [15:0] data_in,
    output logic        trg_enb_out,
    output logic        data_trans_enb_out,
    output logic [15:0] ctrl_reg_out,
    output logic        cmd_rst_out,
    output logic        cycled_trg_bgn_out,
    output logic [15:0] cmd_reg_out,
    output logic [7:0]  logic_grp0_mux_out,
    output logic [1:0]  logic_grp0_sel_out,
    output logic [7:0]  logic_grp1_mux_out,
    output logic [1:0]  logic_grp1_sel_out,
    output logic [7:0]  logic_grp2_mux_out,
    output logic [1:0]  logic_grp2_sel_out,
    output logic [7:0]  logic_grp3_mux_out,
    output logic [1:0]  logic_grp3_sel_out,
    output logic [7:0]  logic_grp4_mux_out,
    output logic [1:0]  logic_grp4_sel_out,
    output logic [5:0]  coincid_MIP1_div_out,
    output logic [5:0]  coincid_MIP2_div_out,
    output logic [5:0]  coincid_UBS_div_out,
    output logic [1:0]  logic_burst_sel_out,
    output logic [15:0] hit_ab_sel_out,
    output logic [15:0] hit_mask_out,
    output logic [2:0]  hit_monit_fix_sel_out,
    output logic        busy_monit_fix_sel_out,
    output logic [1:0]  busy_ab_sel_out,
    output logic [1:0]  busy_mask_out,
    output logic        busy_ignore_out,
    output logic [7:0]  acd_csi_hit_tim_diff_out,
    output logic [3:0]  acd_fee_top_hit_align_out,
    output logic [3:0]  acd_fee_sec_hit_align_out,
    output logic [3:0]  acd_fee_sid_hit_align_out,
    output logic [3:0]  csi_hit_align_out,
    output logic [3:0]  cal_fee_1_hit_align_out,
    output logic [3:0]  cal_fee_2_hit_align_out,
    output logic [3:0]  cal_fee_3_hit_align_out,
    output logic [3:0]  cal_fee_4_hit_align_out,
    output logic [15:0] trg_match_win_out,
    output logic [7:0]  trg_dead_time_out,
    output logic [7:0]  logic_grp_oe_out,
    output logic [7:0]  cycled_trg_period_out,
    output logic [7:0]  ext_trg_delay_out,
    output logic [15:0] cycled_trg_num_out,
    output logic [15:0] config_received_out
);

    logic [REG_COUNT-1:0] sel;
    logic [GRP_MUX_W-1:0] grp_mux_reg [GRP_COUNT];
    logic [GRP_SEL_W-1:0] grp_sel_reg [GRP_COUNT];

    // One-hot address decode; addresses beyond the map select nothing.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_decode
            assign sel[gi] = wr_in && (wr_addr_in == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in)              ctrl_reg_out <= '0;
        else if (sel[ADDR_CTRL]) ctrl_reg_out <= data_in;
    end

    assign trg_enb_out        = ctrl_reg_out[CTRL_TRG_ENB_BIT];
    assign data_trans_enb_out = ctrl_reg_out[CTRL_DATA_TRANS_BIT];

    // Pulses are re-evaluated every cycle, so a held write produces a continuous high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cmd_reg_out        <= '0;
            cmd_rst_out        <= 1'b0;
            cycled_trg_bgn_out <= 1'b0;
        end else begin
            if (sel[ADDR_CMD]) cmd_reg_out <= data_in;
            cmd_rst_out        <= sel[ADDR_CMD] && data_in[CMD_RST_BIT];
            cycled_trg_bgn_out <= sel[ADDR_CMD] && data_in[CMD_CYCLED_BGN_BIT];
        end
    end

    generate
        for (genvar gi = 0; gi < GRP_COUNT; gi++) begin : g_grp
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    grp_mux_reg[gi] <= '0;
                    grp_sel_reg[gi] <= '0;
                end else if (sel[int'(ADDR_LOGIC_GRP0) + gi]) begin
                    grp_mux_reg[gi] <= data_in[GRP_MUX_LSB +: GRP_MUX_W];
                    grp_sel_reg[gi] <= data_in[GRP_SEL_LSB +: GRP_SEL_W];
                end
            end
        end
    endgenerate

    assign logic_grp0_mux_out = grp_mux_reg[0];
    assign logic_grp1_mux_out = grp_mux_reg[1];
    assign logic_grp2_mux_out = grp_mux_reg[2];
    assign logic_grp3_mux_out = grp_mux_reg[3];
    assign logic_grp4_mux_out = grp_mux_reg[4];
    assign logic_grp0_sel_out = grp_sel_reg[0];
    assign logic_grp1_sel_out = grp_sel_reg[1];
    assign logic_grp2_sel_out = grp_sel_reg[2];
    assign logic_grp3_sel_out = grp_sel_reg[3];
    assign logic_grp4_sel_out = grp_sel_reg[4];

    // Coincidence dividers share the upper bits of groups 0, 1 and 4.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            coincid_MIP1_div_out <= '0;
            coincid_MIP2_div_out <= '0;
            coincid_UBS_div_out  <= '0;
        end else begin
            if (sel[ADDR_LOGIC_GRP0]) coincid_MIP1_div_out <= data_in[COINCID_DIV_LSB +: COINCID_DIV_W];
            if (sel[ADDR_LOGIC_GRP1]) coincid_MIP2_div_out <= data_in[COINCID_DIV_LSB +: COINCID_DIV_W];
            if (sel[ADDR_LOGIC_GRP4]) coincid_UBS_div_out  <= data_in[COINCID_DIV_LSB +: COINCID_DIV_W];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                         logic_burst_sel_out <= '0;
        else if (sel[ADDR_LOGIC_BURST_SEL]) logic_burst_sel_out <= data_in[1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                    hit_ab_sel_out <= '0;
        else if (sel[ADDR_HIT_AB_SEL]) hit_ab_sel_out <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                  hit_mask_out <= '0;
        else if (sel[ADDR_HIT_MASK]) hit_mask_out <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_monit_fix_sel_out  <= '0;
            busy_monit_fix_sel_out <= 1'b0;
        end else if (sel[ADDR_MONIT_FIX_SEL]) begin
            hit_monit_fix_sel_out  <= data_in[HIT_MONIT_LSB +: HIT_MONIT_W];
            busy_monit_fix_sel_out <= data_in[BUSY_MONIT_BIT];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_ab_sel_out <= '0;
            busy_mask_out   <= '0;
            busy_ignore_out <= 1'b0;
        end else if (sel[ADDR_BUSY_CFG]) begin
            busy_ab_sel_out <= data_in[BUSY_AB_LSB +: 2];
            busy_mask_out   <= data_in[BUSY_MASK_LSB +: 2];
            busy_ignore_out <= data_in[BUSY_IGNORE_BIT];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                          acd_csi_hit_tim_diff_out <= '0;
        else if (sel[ADDR_ACD_CSI_TIM_DIFF]) acd_csi_hit_tim_diff_out <= data_in[BYTE_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acd_fee_top_hit_align_out <= '0;
            acd_fee_sec_hit_align_out <= '0;
            acd_fee_sid_hit_align_out <= '0;
            csi_hit_align_out         <= '0;
        end else if (sel[ADDR_ACD_CSI_ALIGN]) begin
            acd_fee_top_hit_align_out <= data_in[0*ALIGN_W +: ALIGN_W];
            acd_fee_sec_hit_align_out <= data_in[1*ALIGN_W +: ALIGN_W];
            acd_fee_sid_hit_align_out <= data_in[2*ALIGN_W +: ALIGN_W];
            csi_hit_align_out         <= data_in[3*ALIGN_W +: ALIGN_W];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cal_fee_1_hit_align_out <= '0;
            cal_fee_2_hit_align_out <= '0;
            cal_fee_3_hit_align_out <= '0;
            cal_fee_4_hit_align_out <= '0;
        end else if (sel[ADDR_CAL_ALIGN]) begin
            cal_fee_1_hit_align_out <= data_in[0*ALIGN_W +: ALIGN_W];
            cal_fee_2_hit_align_out <= data_in[1*ALIGN_W +: ALIGN_W];
            cal_fee_3_hit_align_out <= data_in[2*ALIGN_W +: ALIGN_W];
            cal_fee_4_hit_align_out <= data_in[3*ALIGN_W +: ALIGN_W];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                       trg_match_win_out <= '0;
        else if (sel[ADDR_TRG_MATCH_WIN]) trg_match_win_out <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                       trg_dead_time_out <= '0;
        else if (sel[ADDR_TRG_DEAD_TIME]) trg_dead_time_out <= data_in[BYTE_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                      logic_grp_oe_out <= '0;
        else if (sel[ADDR_LOGIC_GRP_OE]) logic_grp_oe_out <= data_in[BYTE_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                           cycled_trg_period_out <= '0;
        else if (sel[ADDR_CYCLED_TRG_PERIOD]) cycled_trg_period_out <= data_in[BYTE_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                        cycled_trg_num_out <= '0;
        else if (sel[ADDR_CYCLED_TRG_NUM]) cycled_trg_num_out <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                       ext_trg_delay_out <= '0;
        else if (sel[ADDR_EXT_TRG_DELAY]) ext_trg_delay_out <= data_in[BYTE_W-1:0];
    end

    // Counts mapped writes only; natural 16-bit wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in)                                  config_received_out <= '0;
        else if (wr_in && addr_mapped(wr_addr_in))   config_received_out <= config_received_out + 16'd1;
    end

endmodule

// File: tb/tb_config_reg.sv
// Directed bench for config_reg: hand-computed expectations per write,
// pulse timing, unmapped addresses, reset priority and counter wrap.
module tb_config_reg;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wr_in;
    logic [7:0]  wr_addr_in;
    logic [15:0] data_in;

    logic        trg_enb_out, data_trans_enb_out;
    logic [15:0] ctrl_reg_out;
    logic        cmd_rst_out, cycled_trg_bgn_out;
    logic [15:0] cmd_reg_out;
    logic [7:0]  logic_grp0_mux_out, logic_grp1_mux_out, logic_grp2_mux_out, logic_grp3_mux_out, logic_grp4_mux_out;
    logic [1:0]  logic_grp0_sel_out, logic_grp1_sel_out, logic_grp2_sel_out, logic_grp3_sel_out, logic_grp4_sel_out;
    logic [5:0]  coincid_MIP1_div_out, coincid_MIP2_div_out, coincid_UBS_div_out;
    logic [1:0]  logic_burst_sel_out;
    logic [15:0] hit_ab_sel_out, hit_mask_out;
    logic [2:0]  hit_monit_fix_sel_out;
    logic        busy_monit_fix_sel_out;
    logic [1:0]  busy_ab_sel_out, busy_mask_out;
    logic        busy_ignore_out;
    logic [7:0]  acd_csi_hit_tim_diff_out;
    logic [3:0]  acd_fee_top_hit_align_out, acd_fee_sec_hit_align_out, acd_fee_sid_hit_align_out, csi_hit_align_out;
    logic [3:0]  cal_fee_1_hit_align_out, cal_fee_2_hit_align_out, cal_fee_3_hit_align_out, cal_fee_4_hit_align_out;
    logic [15:0] trg_match_win_out;
    logic [7:0]  trg_dead_time_out, logic_grp_oe_out, cycled_trg_period_out, ext_trg_delay_out;
    logic [15:0] cycled_trg_num_out, config_received_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_in = ~clk_in;

    config_reg dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_in(wr_in), .wr_addr_in(wr_addr_in), .data_in(data_in),
        .trg_enb_out(trg_enb_out), .data_trans_enb_out(data_trans_enb_out), .ctrl_reg_out(ctrl_reg_out),
        .cmd_rst_out(cmd_rst_out), .cycled_trg_bgn_out(cycled_trg_bgn_out), .cmd_reg_out(cmd_reg_out),
        .logic_grp0_mux_out(logic_grp0_mux_out), .logic_grp0_sel_out(logic_grp0_sel_out),
        .logic_grp1_mux_out(logic_grp1_mux_out), .logic_grp1_sel_out(logic_grp1_sel_out),
        .logic_grp2_mux_out(logic_grp2_mux_out), .logic_grp2_sel_out(logic_grp2_sel_out),
        .logic_grp3_mux_out(logic_grp3_mux_out), .logic_grp3_sel_out(logic_grp3_sel_out),
        .logic_grp4_mux_out(logic_grp4_mux_out), .logic_grp4_sel_out(logic_grp4_sel_out),
        .coincid_MIP1_div_out(coincid_MIP1_div_out), .coincid_MIP2_div_out(coincid_MIP2_div_out),
        .coincid_UBS_div_out(coincid_UBS_div_out), .logic_burst_sel_out(logic_burst_sel_out),
        .hit_ab_sel_out(hit_ab_sel_out), .hit_mask_out(hit_mask_out),
        .hit_monit_fix_sel_out(hit_monit_fix_sel_out), .busy_monit_fix_sel_out(busy_monit_fix_sel_out),
        .busy_ab_sel_out(busy_ab_sel_out), .busy_mask_out(busy_mask_out), .busy_ignore_out(busy_ignore_out),
        .acd_csi_hit_tim_diff_out(acd_csi_hit_tim_diff_out),
        .acd_fee_top_hit_align_out(acd_fee_top_hit_align_out), .acd_fee_sec_hit_align_out(acd_fee_sec_hit_align_out),
        .acd_fee_sid_hit_align_out(acd_fee_sid_hit_align_out), .csi_hit_align_out(csi_hit_align_out),
        .cal_fee_1_hit_align_out(cal_fee_1_hit_align_out), .cal_fee_2_hit_align_out(cal_fee_2_hit_align_out),
        .cal_fee_3_hit_align_out(cal_fee_3_hit_align_out), .cal_fee_4_hit_align_out(cal_fee_4_hit_align_out),
        .trg_match_win_out(trg_match_win_out), .trg_dead_time_out(trg_dead_time_out),
        .logic_grp_oe_out(logic_grp_oe_out), .cycled_trg_period_out(cycled_trg_period_out),
        .ext_trg_delay_out(ext_trg_delay_out), .cycled_trg_num_out(cycled_trg_num_out),
        .config_received_out(config_received_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Single-cycle write; returns at the falling edge after the capturing rising edge.
    task automatic write_reg(input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk_in);
        wr_in = 1'b1; wr_addr_in = addr; data_in = data;
        @(negedge clk_in);
        wr_in = 1'b0;
        $display("[TB] write addr=0x%02h data=0x%04h -> count=%0d", addr, data, config_received_out);
    endtask

    initial begin
        rst_in = 1'b1; wr_in = 1'b0; wr_addr_in = '0; data_in = '0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        check_eq("rst_ctrl", 32'(ctrl_reg_out), 32'h0);
        check_eq("rst_cmd", 32'(cmd_reg_out), 32'h0);
        check_eq("rst_pulses", 32'({cmd_rst_out, cycled_trg_bgn_out}), 32'h0);
        check_eq("rst_grp0", 32'({logic_grp0_mux_out, logic_grp0_sel_out}), 32'h0);
        check_eq("rst_match_win", 32'(trg_match_win_out), 32'h0);
        check_eq("rst_count", 32'(config_received_out), 32'h0);

        write_reg(8'h00, 16'h0005);
        check_eq("ctrl", 32'(ctrl_reg_out), 32'h0005);
        check_eq("trg_enb", 32'(trg_enb_out), 32'h1);
        check_eq("data_trans_enb", 32'(data_trans_enb_out), 32'h0);
        check_eq("count_1", 32'(config_received_out), 32'd1);

        write_reg(8'h03, 16'h0055);
        check_eq("grp1_mux", 32'(logic_grp1_mux_out), 32'h55);
        check_eq("grp1_sel", 32'(logic_grp1_sel_out), 32'h0);
        check_eq("mip2_div", 32'(coincid_MIP2_div_out), 32'h0);
        check_eq("grp0_untouched", 32'(logic_grp0_mux_out), 32'h0);

        write_reg(8'h02, 16'hFDAB);
        check_eq("grp0_mux", 32'(logic_grp0_mux_out), 32'hAB);
        check_eq("grp0_sel", 32'(logic_grp0_sel_out), 32'h1);
        check_eq("mip1_div", 32'(coincid_MIP1_div_out), 32'h3F);
        check_eq("grp1_kept", 32'(logic_grp1_mux_out), 32'h55);

        write_reg(8'h06, 16'h8E12);
        check_eq("grp4_mux", 32'(logic_grp4_mux_out), 32'h12);
        check_eq("grp4_sel", 32'(logic_grp4_sel_out), 32'h2);
        check_eq("ubs_div", 32'(coincid_UBS_div_out), 32'h23);
        check_eq("count_4", 32'(config_received_out), 32'd4);

        write_reg(8'h01, 16'h0001);
        check_eq("cmd_rst_hi", 32'(cmd_rst_out), 32'h1);
        check_eq("cyc_bgn_lo", 32'(cycled_trg_bgn_out), 32'h0);
        check_eq("cmd_reg", 32'(cmd_reg_out), 32'h0001);
        @(negedge clk_in);
        check_eq("cmd_rst_drop", 32'(cmd_rst_out), 32'h0);
        check_eq("cmd_reg_hold", 32'(cmd_reg_out), 32'h0001);

        // Held write to the command register: pulse stays high every cycle
        @(negedge clk_in);
        wr_in = 1'b1; wr_addr_in = 8'h01; data_in = 16'h0002;
        @(negedge clk_in);
        check_eq("cyc_bgn_hold1", 32'(cycled_trg_bgn_out), 32'h1);
        @(negedge clk_in);
        check_eq("cyc_bgn_hold2", 32'(cycled_trg_bgn_out), 32'h1);
        check_eq("count_7", 32'(config_received_out), 32'd7);
        wr_in = 1'b0;
        $display("[TB] held write addr=0x01 data=0x0002 for 2 cycles");
        @(negedge clk_in);
        check_eq("cyc_bgn_end", 32'(cycled_trg_bgn_out), 32'h0);

        write_reg(8'h20, 16'hFFFF);
        write_reg(8'hFF, 16'hFFFF);
        check_eq("unmapped_count", 32'(config_received_out), 32'd7);
        check_eq("unmapped_ctrl", 32'(ctrl_reg_out), 32'h0005);
        check_eq("unmapped_cmd", 32'(cmd_reg_out), 32'h0002);

        write_reg(8'h0A, 16'hFFFF);
        check_eq("monit_fix", 32'({hit_monit_fix_sel_out, busy_monit_fix_sel_out}), 32'hF);
        write_reg(8'h0B, 16'h001E);
        check_eq("busy_cfg", 32'({busy_ignore_out, busy_mask_out, busy_ab_sel_out}), 32'h1E);
        write_reg(8'h0D, 16'hBA98);
        check_eq("acd_csi_align", 32'({csi_hit_align_out, acd_fee_sid_hit_align_out,
                                       acd_fee_sec_hit_align_out, acd_fee_top_hit_align_out}), 32'hBA98);
        write_reg(8'h0E, 16'h4321);
        check_eq("cal_align", 32'({cal_fee_4_hit_align_out, cal_fee_3_hit_align_out,
                                   cal_fee_2_hit_align_out, cal_fee_1_hit_align_out}), 32'h4321);
        write_reg(8'h13, 16'hBEEF);
        check_eq("cyc_trg_num", 32'(cycled_trg_num_out), 32'hBEEF);
        write_reg(8'h14, 16'h12A5);
        check_eq("ext_trg_delay", 32'(ext_trg_delay_out), 32'hA5);
        write_reg(8'h10, 16'h0133);
        check_eq("dead_time", 32'(trg_dead_time_out), 32'h33);
        write_reg(8'h11, 16'hFF44);
        check_eq("grp_oe", 32'(logic_grp_oe_out), 32'h44);
        write_reg(8'h12, 16'h0077);
        check_eq("cyc_period", 32'(cycled_trg_period_out), 32'h77);
        write_reg(8'h07, 16'hFFFF);
        check_eq("burst_sel", 32'(logic_burst_sel_out), 32'h3);
        write_reg(8'h08, 16'h1111);
        check_eq("hit_ab_sel", 32'(hit_ab_sel_out), 32'h1111);
        write_reg(8'h09, 16'h2222);
        check_eq("hit_mask", 32'(hit_mask_out), 32'h2222);
        write_reg(8'h0C, 16'hFF5A);
        check_eq("tim_diff", 32'(acd_csi_hit_tim_diff_out), 32'h5A);
        write_reg(8'h04, 16'h0301);
        check_eq("grp2", 32'({logic_grp2_sel_out, logic_grp2_mux_out}), 32'h301);
        write_reg(8'h05, 16'h0210);
        check_eq("grp3", 32'({logic_grp3_sel_out, logic_grp3_mux_out}), 32'h210);
        check_eq("count_22", 32'(config_received_out), 32'd22);

        // Reset wins over a simultaneous write
        @(negedge clk_in);
        rst_in = 1'b1; wr_in = 1'b1; wr_addr_in = 8'h0F; data_in = 16'h1234;
        @(negedge clk_in);
        rst_in = 1'b0; wr_in = 1'b0;
        $display("[TB] reset with write addr=0x0F data=0x1234");
        check_eq("rst_wr_match_win", 32'(trg_match_win_out), 32'h0);
        check_eq("rst_wr_count", 32'(config_received_out), 32'h0);
        check_eq("rst_wr_ctrl", 32'(ctrl_reg_out), 32'h0);
        check_eq("rst_wr_grp3", 32'(logic_grp3_mux_out), 32'h0);

        write_reg(8'h0F, 16'h1234);
        check_eq("match_win", 32'(trg_match_win_out), 32'h1234);
        check_eq("count_after_rst", 32'(config_received_out), 32'd1);

        // Counter wrap: 65534 more writes reach 0xFFFF, one more wraps to 0
        @(negedge clk_in);
        wr_in = 1'b1; wr_addr_in = 8'h11; data_in = 16'h00C3;
        repeat (65534) @(negedge clk_in);
        check_eq("count_ffff", 32'(config_received_out), 32'hFFFF);
        @(negedge clk_in);
        wr_in = 1'b0;
        $display("[TB] burst of 65535 writes to addr=0x11");
        check_eq("count_wrap", 32'(config_received_out), 32'h0);
        check_eq("burst_grp_oe", 32'(logic_grp_oe_out), 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
